// File: rtl/reg_bus_fabric.sv
// Register-bus fabric: one reg-bus master fanned out to NUM_SLV register blocks, with a decode-miss
// error response and a saturating error counter. Define REG_BUS_TIMEOUT_EN to build the slave-timeout watchdog.
module reg_bus_fabric #(
    parameter int NUM_SLV = 2,
    parameter int SEL_LSB = 6,
    parameter int SEL_W   = 3,
    parameter int TIMEOUT = 255
) (
    input  logic                   app_clk,
    input  logic                   app_rst,
    input  logic                   reg_cs,
    input  logic                   reg_wr,
    input  logic [10:0]            reg_addr,
    input  logic [31:0]            reg_wdata,
    input  logic [3:0]             reg_be,
    output logic [31:0]            reg_rdata,
    output logic                   reg_ack,
    output logic                   reg_err,
    output logic [NUM_SLV-1:0]     s_cs,
    input  logic [32*NUM_SLV-1:0]  s_rdata,
    input  logic [NUM_SLV-1:0]     s_ack,
    output logic [7:0]             err_cnt
);
    typedef enum logic [1:0] {IDLE, DECODE, WAIT, RESP} state_t;

    state_t             state, state_nxt;
    logic [SEL_W-1:0]   sel_q;
    logic [NUM_SLV-1:0] sel_hot;
    logic               sel_hit;
    logic               ack_sel;
    logic               to_hit;
    logic [31:0]        rdata_sel;
    logic               load_resp;
    logic               resp_err;
    logic [31:0]        resp_data;

    // Write-side master signals are wired straight to every slave at the cluster level.
    logic unused_fanout;
    assign unused_fanout = ^{reg_wr, reg_addr, reg_wdata, reg_be};

    assign sel_hit = {1'b0, sel_q} < (SEL_W+1)'(NUM_SLV);

    always_comb begin
        sel_hot   = '0;
        rdata_sel = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            sel_hot[i] = (sel_q == SEL_W'(i));
            rdata_sel  = rdata_sel | (s_rdata[32*i +: 32] & {32{sel_q == SEL_W'(i)}});
        end
    end

    // Only the selected slave's ack counts; strays from idle slaves are masked here.
    assign ack_sel = |(s_ack & sel_hot);

`ifdef REG_BUS_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt;

    assign to_hit = (to_cnt == TO_W'(TIMEOUT - 1));

    always_ff @(posedge app_clk) begin
        if (app_rst)
            to_cnt <= '0;
        else if (state == WAIT && reg_cs && !ack_sel)
            to_cnt <= to_cnt + 1'b1;
        else
            to_cnt <= '0;
    end
`else
    assign to_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        load_resp = 1'b0;
        resp_err  = 1'b0;
        resp_data = '0;
        s_cs      = '0;
        case (state)
            IDLE: begin
                if (reg_cs) state_nxt = DECODE;
            end
            DECODE: begin
                if (sel_hit) begin
                    state_nxt = WAIT;
                end else begin
                    state_nxt = RESP;
                    load_resp = 1'b1;
                    resp_err  = 1'b1;
                end
            end
            WAIT: begin
                s_cs = reg_cs ? sel_hot : '0;
                // Abort beats a same-cycle ack, and an ack beats a same-cycle timeout.
                if (!reg_cs) begin
                    state_nxt = IDLE;
                end else if (ack_sel) begin
                    state_nxt = RESP;
                    load_resp = 1'b1;
                    resp_data = rdata_sel;
                end else if (to_hit) begin
                    state_nxt = RESP;
                    load_resp = 1'b1;
                    resp_err  = 1'b1;
                    resp_data = 32'hDEAD_0000 | 32'(sel_q);
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge app_clk) begin
        if (app_rst) begin
            state     <= IDLE;
            sel_q     <= '0;
            reg_rdata <= '0;
            reg_ack   <= 1'b0;
            reg_err   <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state   <= state_nxt;
            reg_ack <= load_resp;
            if (state == IDLE && reg_cs)
                sel_q <= reg_addr[SEL_LSB +: SEL_W];
            if (load_resp) begin
                reg_err   <= resp_err;
                reg_rdata <= resp_data;
            end
            if (state == RESP && reg_err && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_reg_bus_fabric.sv
// Scoreboard bench for reg_bus_fabric: expected responses are queued at request time and popped on reg_ack.
// The timeout scenario runs only when REG_BUS_TIMEOUT_EN is defined.
module tb_reg_bus_fabric;
    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_cs, reg_wr;
    logic [10:0] reg_addr;
    logic [31:0] reg_wdata;
    logic [3:0]  reg_be;
    logic [31:0] reg_rdata;
    logic        reg_ack, reg_err;
    logic [1:0]  s_cs;
    logic [63:0] s_rdata;
    logic [1:0]  s_ack;
    logic [7:0]  err_cnt;

    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    exp_t        exp_q[$];

    // Slave model: slave i acks on its dly[i]-th s_cs cycle (0 = never).
    int          dly[2] = '{0, 0};
    int          wcnt[2] = '{0, 0};
    logic [31:0] sdata[2] = '{32'h0, 32'h0};
    logic        stray_en = 1'b0;
    logic [1:0]  ack_force = 2'b00;

    reg_bus_fabric #(.NUM_SLV(2), .SEL_LSB(6), .SEL_W(3), .TIMEOUT(4)) dut (
        .app_clk(clk), .app_rst(rst), .reg_cs(reg_cs), .reg_wr(reg_wr), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_be(reg_be), .reg_rdata(reg_rdata), .reg_ack(reg_ack),
        .reg_err(reg_err), .s_cs(s_cs), .s_rdata(s_rdata), .s_ack(s_ack), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 2; i++) wcnt[i] <= s_cs[i] ? wcnt[i] + 1 : 0;
    end

    always_comb begin
        s_ack   = '0;
        s_rdata = '0;
        for (int i = 0; i < 2; i++) begin
            s_ack[i] = ack_force[i] | (stray_en & ~s_cs[i]) |
                       (s_cs[i] & (dly[i] != 0) & (wcnt[i] == dly[i] - 1));
            s_rdata[32*i +: 32] = sdata[i];
        end
    end

    // Drives one access from mid-cycle and collects what the DUT did; comparisons live in the tests.
    task automatic do_access(input logic wr, input logic [10:0] addr, input logic [1:0] exp_cs,
                             input int budget, output logic got, output int lat,
                             output logic [31:0] rd, output logic er, output int cs_cyc,
                             output int cs_bad, output logic ack_long, output int t_ack);
        reg_wr = wr; reg_addr = addr; reg_wdata = $urandom; reg_be = 4'hF; reg_cs = 1'b1;
        got = 1'b0; lat = 0; rd = '0; er = 1'b0; cs_cyc = 0; cs_bad = 0; t_ack = 0;
        while (!got && lat < budget) begin
            @(negedge clk);
            lat++;
            if (exp_cs != 2'b00 && s_cs === exp_cs) cs_cyc++;
            else if (s_cs !== 2'b00) cs_bad++;
            if (reg_ack === 1'b1) begin
                got = 1'b1; rd = reg_rdata; er = reg_err; t_ack = cyc;
            end
        end
        @(posedge clk); #1 reg_cs = 1'b0;
        @(negedge clk);
        ack_long = reg_ack;
    endtask

    task automatic test_reset();
        rst = 1'b1; reg_cs = 1'b0; reg_wr = 1'b0; reg_addr = '0; reg_wdata = '0; reg_be = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_chk++; if (reg_ack !== 1'b0) $display("FAIL rst_ack got %b exp 0", reg_ack); else n_pass++;
        n_chk++; if (reg_err !== 1'b0) $display("FAIL rst_err got %b exp 0", reg_err); else n_pass++;
        n_chk++; if (reg_rdata !== 32'h0) $display("FAIL rst_rdata got %h exp 0", reg_rdata); else n_pass++;
        n_chk++; if (s_cs !== 2'b00) $display("FAIL rst_s_cs got %b exp 00", s_cs); else n_pass++;
        n_chk++; if (err_cnt !== 8'h00) $display("FAIL rst_err_cnt got %h exp 00", err_cnt); else n_pass++;
    endtask

    task automatic test_normal_read();
        logic got, er, al; int lat, cc, cb, ta; logic [31:0] rd; exp_t e;
        dly[1] = 2; sdata[1] = 32'h1234_5678;
        exp_q.push_back('{rdata: 32'h1234_5678, err: 1'b0});
        do_access(1'b0, 11'h040, 2'b10, 20, got, lat, rd, er, cc, cb, al, ta);
        e = exp_q.pop_front();
        n_chk++; if (got !== 1'b1) $display("FAIL rd_ack got %b exp 1", got); else n_pass++;
        n_chk++; if (lat !== 4) $display("FAIL rd_latency got %0d exp 4", lat); else n_pass++;
        n_chk++; if (rd !== e.rdata) $display("FAIL rd_rdata got %h exp %h", rd, e.rdata); else n_pass++;
        n_chk++; if (er !== e.err) $display("FAIL rd_err got %b exp %b", er, e.err); else n_pass++;
        n_chk++; if (cc !== 2) $display("FAIL rd_s_cs_cycles got %0d exp 2", cc); else n_pass++;
        n_chk++; if (cb !== 0) $display("FAIL rd_s_cs_wrong got %0d exp 0", cb); else n_pass++;
        n_chk++; if (al !== 1'b0) $display("FAIL rd_ack_width got %b exp 0", al); else n_pass++;
    endtask

    task automatic test_decode_miss();
        logic got, er, al; int lat, cc, cb, ta; logic [31:0] rd; exp_t e;
        exp_q.push_back('{rdata: 32'h0, err: 1'b1});
        do_access(1'b0, 11'h0C0, 2'b00, 20, got, lat, rd, er, cc, cb, al, ta);
        e = exp_q.pop_front();
        n_chk++; if (got !== 1'b1) $display("FAIL miss_ack got %b exp 1", got); else n_pass++;
        n_chk++; if (lat !== 2) $display("FAIL miss_latency got %0d exp 2", lat); else n_pass++;
        n_chk++; if (rd !== e.rdata) $display("FAIL miss_rdata got %h exp %h", rd, e.rdata); else n_pass++;
        n_chk++; if (er !== e.err) $display("FAIL miss_err got %b exp %b", er, e.err); else n_pass++;
        n_chk++; if (cb !== 0) $display("FAIL miss_s_cs got %0d cycles exp 0", cb); else n_pass++;
        n_chk++; if (err_cnt !== 8'd1) $display("FAIL miss_err_cnt got %0d exp 1", err_cnt); else n_pass++;
    endtask

    task automatic test_stray_ack();
        logic got, er, al; int lat, cc, cb, ta; logic [31:0] rd; exp_t e;
        dly[1] = 3; sdata[1] = 32'hCAFE_F00D; stray_en = 1'b1;
        exp_q.push_back('{rdata: 32'hCAFE_F00D, err: 1'b0});
        do_access(1'b0, 11'h040, 2'b10, 20, got, lat, rd, er, cc, cb, al, ta);
        stray_en = 1'b0;
        e = exp_q.pop_front();
        n_chk++; if (lat !== 5) $display("FAIL stray_latency got %0d exp 5", lat); else n_pass++;
        n_chk++; if (cc !== 3) $display("FAIL stray_s_cs_cycles got %0d exp 3", cc); else n_pass++;
        n_chk++; if (rd !== e.rdata) $display("FAIL stray_rdata got %h exp %h", rd, e.rdata); else n_pass++;
        n_chk++; if (er !== e.err) $display("FAIL stray_err got %b exp %b", er, e.err); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic got, er, al; int lat, cc, cb, ta0, ta1; logic [31:0] rd; exp_t e;
        dly[0] = 1; dly[1] = 1; sdata[0] = 32'hA5A5_0001; sdata[1] = 32'h5A5A_0002;
        exp_q.push_back('{rdata: 32'hA5A5_0001, err: 1'b0});
        exp_q.push_back('{rdata: 32'h5A5A_0002, err: 1'b0});
        do_access(1'b1, 11'h004, 2'b01, 20, got, lat, rd, er, cc, cb, al, ta0);
        e = exp_q.pop_front();
        n_chk++; if (lat !== 3) $display("FAIL b2b_wr_latency got %0d exp 3", lat); else n_pass++;
        n_chk++; if (rd !== e.rdata || er !== e.err) $display("FAIL b2b_wr_resp got %h/%b exp %h/%b", rd, er, e.rdata, e.err); else n_pass++;
        do_access(1'b0, 11'h07C, 2'b10, 20, got, lat, rd, er, cc, cb, al, ta1);
        e = exp_q.pop_front();
        n_chk++; if (rd !== e.rdata || er !== e.err) $display("FAIL b2b_rd_resp got %h/%b exp %h/%b", rd, er, e.rdata, e.err); else n_pass++;
        n_chk++; if (ta1 - ta0 !== 4) $display("FAIL b2b_spacing got %0d exp 4", ta1 - ta0); else n_pass++;
    endtask

    task automatic test_abort();
        logic got, er, al; int lat, cc, cb, ta, acks, csn; logic [31:0] rd; exp_t e;
        dly[0] = 0;
        reg_wr = 1'b0; reg_addr = 11'h000; reg_cs = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++; if (s_cs !== 2'b01) $display("FAIL abort_s_cs_wait got %b exp 01", s_cs); else n_pass++;
        @(negedge clk);
        reg_cs = 1'b0;
        acks = 0; csn = 0;
        repeat (3) begin
            @(negedge clk);
            if (reg_ack !== 1'b0) acks++;
            if (s_cs !== 2'b00) csn++;
        end
        n_chk++; if (acks !== 0) $display("FAIL abort_no_ack got %0d acks exp 0", acks); else n_pass++;
        n_chk++; if (csn !== 0) $display("FAIL abort_s_cs_idle got %0d cycles exp 0", csn); else n_pass++;
        // Ack and abort in the same WAIT cycle: the abort must win.
        reg_cs = 1'b1;
        repeat (2) @(negedge clk);
        reg_cs = 1'b0; ack_force = 2'b01;
        @(posedge clk); #1 ack_force = 2'b00;
        acks = 0;
        repeat (3) begin
            @(negedge clk);
            if (reg_ack !== 1'b0) acks++;
        end
        n_chk++; if (acks !== 0) $display("FAIL abort_vs_ack got %0d acks exp 0", acks); else n_pass++;
        dly[0] = 1; sdata[0] = 32'h0BAD_BEEF;
        exp_q.push_back('{rdata: 32'h0BAD_BEEF, err: 1'b0});
        do_access(1'b0, 11'h000, 2'b01, 20, got, lat, rd, er, cc, cb, al, ta);
        e = exp_q.pop_front();
        n_chk++; if (lat !== 3) $display("FAIL post_abort_latency got %0d exp 3", lat); else n_pass++;
        n_chk++; if (rd !== e.rdata || er !== e.err) $display("FAIL post_abort_resp got %h/%b exp %h/%b", rd, er, e.rdata, e.err); else n_pass++;
    endtask

`ifdef REG_BUS_TIMEOUT_EN
    task automatic test_timeout();
        logic got, er, al; int lat, cc, cb, ta; logic [7:0] cnt0; logic [31:0] rd; exp_t e;
        cnt0 = err_cnt;
        dly[0] = 0;
        exp_q.push_back('{rdata: 32'hDEAD_0000, err: 1'b1});
        do_access(1'b0, 11'h000, 2'b01, 20, got, lat, rd, er, cc, cb, al, ta);
        e = exp_q.pop_front();
        n_chk++; if (lat !== 6) $display("FAIL to_latency got %0d exp 6", lat); else n_pass++;
        n_chk++; if (cc !== 4) $display("FAIL to_wait_cycles got %0d exp 4", cc); else n_pass++;
        n_chk++; if (rd !== e.rdata || er !== e.err) $display("FAIL to_resp got %h/%b exp %h/%b", rd, er, e.rdata, e.err); else n_pass++;
        n_chk++; if (err_cnt !== cnt0 + 8'd1) $display("FAIL to_err_cnt got %0d exp %0d", err_cnt, cnt0 + 8'd1); else n_pass++;
        dly[1] = 0;
        exp_q.push_back('{rdata: 32'hDEAD_0001, err: 1'b1});
        do_access(1'b0, 11'h040, 2'b10, 20, got, lat, rd, er, cc, cb, al, ta);
        e = exp_q.pop_front();
        n_chk++; if (rd !== e.rdata || er !== e.err) $display("FAIL to_sel1_resp got %h/%b exp %h/%b", rd, er, e.rdata, e.err); else n_pass++;
        dly[0] = 4; sdata[0] = 32'h7777_0004;
        exp_q.push_back('{rdata: 32'h7777_0004, err: 1'b0});
        do_access(1'b0, 11'h000, 2'b01, 20, got, lat, rd, er, cc, cb, al, ta);
        e = exp_q.pop_front();
        n_chk++; if (lat !== 6) $display("FAIL to_ack_wins_latency got %0d exp 6", lat); else n_pass++;
        n_chk++; if (rd !== e.rdata || er !== e.err) $display("FAIL to_ack_wins_resp got %h/%b exp %h/%b", rd, er, e.rdata, e.err); else n_pass++;
    endtask
`endif

    task automatic test_reset_mid_wait();
        dly[1] = 0;
        reg_wr = 1'b0; reg_addr = 11'h040; reg_cs = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++; if (s_cs !== 2'b10) $display("FAIL rstw_s_cs_before got %b exp 10", s_cs); else n_pass++;
        rst = 1'b1;
        @(posedge clk); #1 reg_cs = 1'b0;
        @(negedge clk);
        n_chk++; if (s_cs !== 2'b00) $display("FAIL rstw_s_cs got %b exp 00", s_cs); else n_pass++;
        n_chk++; if (reg_ack !== 1'b0 || reg_err !== 1'b0) $display("FAIL rstw_ack_err got %b/%b exp 0/0", reg_ack, reg_err); else n_pass++;
        n_chk++; if (reg_rdata !== 32'h0) $display("FAIL rstw_rdata got %h exp 0", reg_rdata); else n_pass++;
        n_chk++; if (err_cnt !== 8'h00) $display("FAIL rstw_err_cnt got %h exp 00", err_cnt); else n_pass++;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_err_saturation();
        logic got, er, al; int lat, cc, cb, ta, misses; logic [31:0] rd;
        misses = 0;
        for (int i = 0; i < 260; i++) begin
            do_access(1'b0, 11'h0C0, 2'b00, 8, got, lat, rd, er, cc, cb, al, ta);
            if (!got) misses++;
            if (i == 253) begin
                n_chk++; if (err_cnt !== 8'hFE) $display("FAIL sat_err_cnt_254 got %h exp fe", err_cnt); else n_pass++;
            end
        end
        n_chk++; if (misses !== 0) $display("FAIL sat_acks got %0d missing exp 0", misses); else n_pass++;
        n_chk++; if (err_cnt !== 8'hFF) $display("FAIL sat_err_cnt got %h exp ff", err_cnt); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_normal_read();
        test_decode_miss();
        test_stray_ack();
        test_back_to_back();
        test_abort();
`ifdef REG_BUS_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_wait();
        test_err_saturation();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
